// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Non-pipelined instruction fetch stage. Requests one word from instruction
//   memory, holds it for the execute stage until it is consumed, then computes
//   the next program counter (sequential, taken branch or jump) and fetches
//   again. At most one instruction every two cycles; no prefetch.
//
// Parameters:
//   RESET_PC     first fetch address (bits [1:0] are ignored)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   imem_req     fetch request to instruction memory (FETCH state only)
//   imem_addr    byte address of the requested word
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   instruction  held instruction for the decoder
//   instr_valid  held instruction is valid (HOLD state)
//   instr_ready  execute consumes the held instruction this cycle
//   is_jump, is_branch, branch_taken, imm16, addr26
//                decoder/datapath results for the held instruction
//   pc           address of the held or in-flight instruction
//   retired      number of consumed instructions (wraps)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    // Word-aligned start address.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        w_latch;
    logic        w_consume;
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

    assign w_pc4    = r_pc + 32'd4;
    // Sign-extended word offset, already shifted to a byte offset.
    assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC selection; jump wins over branch.
    always_comb begin
        w_next_pc = w_pc4;
        if (is_jump) begin
            w_next_pc = {w_pc4[31:28], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            w_next_pc = w_pc4 + w_br_off;
        end else begin
            w_next_pc = w_pc4;
        end
    end

    // FSM next state and the latch/consume strobes.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            FETCH: begin
                if (imem_ack) begin
                    w_next_state = HOLD;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = FETCH;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_next_state = FETCH;
                    w_consume    = 1'b1;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // State, PC, held instruction and retire counter; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= PC_INIT;
            r_instr   <= 32'h0000_0000;
            r_retired <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_instr <= imem_rdata;
            end
            if (w_consume) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Request and valid are qualified by reset so they read inactive for the
    // whole time reset is held, not only after the first reset edge.
    assign imem_req    = (r_state == FETCH) && !reset;
    assign imem_addr   = reset ? PC_INIT : r_pc;
    assign instr_valid = (r_state == HOLD) && !reset;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A main instance (RESET_PC = 0) runs reset,
// first fetch, ack stalls, a table of next-PC vectors and reset-in-HOLD.
// Two extra instances share the stimulus to reach the high-address cases
// (RESET_PC = 0x1000_0043 and 0xFFFF_FFFF, the low bits must be dropped).
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        is_jump;
    logic        is_branch;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] addr26;

    logic        a_req, b_req, c_req;
    logic [31:0] a_addr, b_addr, c_addr;
    logic [31:0] a_instr, b_instr, c_instr;
    logic        a_valid, b_valid, c_valid;
    logic [31:0] a_pc, b_pc, c_pc;
    logic [31:0] a_ret, b_ret, c_ret;

    int n_checks = 0;
    int n_err    = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut_a (
        .clk(clk), .reset(reset), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(a_instr),
        .instr_valid(a_valid), .instr_ready(instr_ready), .is_jump(is_jump),
        .is_branch(is_branch), .branch_taken(branch_taken), .imm16(imm16),
        .addr26(addr26), .pc(a_pc), .retired(a_ret)
    );

    fetch_unit #(.RESET_PC(32'h1000_0043)) u_dut_b (
        .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(b_instr),
        .instr_valid(b_valid), .instr_ready(instr_ready), .is_jump(is_jump),
        .is_branch(is_branch), .branch_taken(branch_taken), .imm16(imm16),
        .addr26(addr26), .pc(b_pc), .retired(b_ret)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_dut_c (
        .clk(clk), .reset(reset), .imem_req(c_req), .imem_addr(c_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(c_instr),
        .instr_valid(c_valid), .instr_ready(instr_ready), .is_jump(is_jump),
        .is_branch(is_branch), .branch_taken(branch_taken), .imm16(imm16),
        .addr26(addr26), .pc(c_pc), .retired(c_ret)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] rdata;    // word fetched after this consume
        logic        jmp;
        logic        br;
        logic        tk;
        logic [15:0] imm;
        logic [25:0] a26;
        logic [31:0] exp_pc;   // pc after the consume
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_flags();
        is_jump      = 1'b0;
        is_branch    = 1'b0;
        branch_taken = 1'b0;
        imm16        = 16'h0000;
        addr26       = 26'h0;
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic [31:0] exp_ret;

        // pc starts at 4 with retired = 1 when the table begins
        vecs[0]  = '{32'hA000_0000, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0000004, 32'h0000_0010};
        vecs[1]  = '{32'hA000_0001, 1'b0, 1'b1, 1'b1, 16'hFFFD, 26'h0000000, 32'h0000_0008};
        vecs[2]  = '{32'hA000_0002, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0000004, 32'h0000_0010};
        vecs[3]  = '{32'hA000_0003, 1'b0, 1'b1, 1'b0, 16'hFFFD, 26'h0000000, 32'h0000_0014};
        vecs[4]  = '{32'hA000_0004, 1'b1, 1'b1, 1'b1, 16'h0001, 26'h0000040, 32'h0000_0100};
        vecs[5]  = '{32'hA000_0005, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0000000, 32'h0000_0144};
        vecs[6]  = '{32'hA000_0006, 1'b0, 1'b0, 1'b1, 16'hFFFF, 26'h3FFFFFF, 32'h0000_0148};
        vecs[7]  = '{32'hA000_0007, 1'b0, 1'b1, 1'b0, 16'h8000, 26'h0000000, 32'h0000_014C};
        vecs[8]  = '{32'hA000_0008, 1'b0, 1'b1, 1'b1, 16'h8000, 26'h0000000, 32'hFFFE_0150};
        vecs[9]  = '{32'hA000_0009, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h3FFFFFF, 32'hFFFF_FFFC};
        vecs[10] = '{32'hA000_000A, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000};

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        clear_flags();

        // ---- reset state ----
        step();
        step();
        chk("rst_req", {31'd0, a_req}, 32'd0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_retired", a_ret, 32'h0);
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_pc", a_pc, 32'h0);

        // ---- first fetch, ack in the first cycle ----
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2010_FEFE;
        settle();
        chk("f1_req", {31'd0, a_req}, 32'd1);
        chk("f1_addr", a_addr, 32'h0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        settle();
        chk("f1_instr", a_instr, 32'h2010_FEFE);
        chk("f1_valid", {31'd0, a_valid}, 32'd1);
        chk("f1_pc", a_pc, 32'h0);
        chk("f1_req_hold", {31'd0, a_req}, 32'd0);

        // ---- sequential consume ----
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        settle();
        chk("seq_pc", a_pc, 32'h4);
        chk("seq_retired", a_ret, 32'h1);
        chk("seq_addr", a_addr, 32'h4);
        chk("seq_req", {31'd0, a_req}, 32'd1);

        // ---- ack delayed 3 cycles, instr_ready ignored in FETCH ----
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("stall_req", {31'd0, a_req}, 32'd1);
            chk("stall_addr", a_addr, 32'h4);
            chk("stall_valid", {31'd0, a_valid}, 32'd0);
            chk("stall_retired", a_ret, 32'h1);
            if (k == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h1234_5678;
            end
            step();
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        settle();
        chk("stall_instr", a_instr, 32'h1234_5678);
        chk("stall_valid_after", {31'd0, a_valid}, 32'd1);
        chk("stall_retired_after", a_ret, 32'h1);

        // ---- table of next-PC vectors ----
        prev_pc    = 32'h4;
        prev_instr = 32'h1234_5678;
        exp_ret    = 32'h1;
        for (int i = 0; i < 11; i++) begin
            // decoder inputs present but not consumed: everything holds
            is_jump      = vecs[i].jmp;
            is_branch    = vecs[i].br;
            branch_taken = vecs[i].tk;
            imm16        = vecs[i].imm;
            addr26       = vecs[i].a26;
            instr_ready  = 1'b0;
            step();
            chk("tbl_hold_pc", a_pc, prev_pc);
            chk("tbl_hold_instr", a_instr, prev_instr);
            chk("tbl_hold_valid", {31'd0, a_valid}, 32'd1);
            // consume
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            clear_flags();
            exp_ret = exp_ret + 32'd1;
            settle();
            chk("tbl_pc", a_pc, vecs[i].exp_pc);
            chk("tbl_addr", a_addr, vecs[i].exp_pc);
            chk("tbl_retired", a_ret, exp_ret);
            chk("tbl_req", {31'd0, a_req}, 32'd1);
            chk("tbl_valid", {31'd0, a_valid}, 32'd0);
            // fetch the next word
            imem_ack   = 1'b1;
            imem_rdata = vecs[i].rdata;
            step();
            imem_ack = 1'b0;
            settle();
            chk("tbl_instr", a_instr, vecs[i].rdata);
            prev_pc    = vecs[i].exp_pc;
            prev_instr = vecs[i].rdata;
        end

        // ---- reset during HOLD, with a stale ack ----
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rh_req_during", {31'd0, a_req}, 32'd0);
        chk("rh_valid_during", {31'd0, a_valid}, 32'd0);
        step();
        chk("rh_valid", {31'd0, a_valid}, 32'd0);
        chk("rh_retired", a_ret, 32'h0);
        chk("rh_pc", a_pc, 32'h0);
        chk("rh_instr", a_instr, 32'h0);
        step();
        chk("rh_instr_stale", a_instr, 32'h0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        settle();
        chk("rh_req_after", {31'd0, a_req}, 32'd1);
        chk("rh_addr_after", a_addr, 32'h0);
        step();
        chk("rh_valid_after", {31'd0, a_valid}, 32'd0);
        chk("rh_instr_after", a_instr, 32'h0);

        // ---- high-address instances: reset values, low bits dropped ----
        reset = 1'b1;
        step();
        chk("c_rst_addr", c_addr, 32'hFFFF_FFFC);
        chk("c_rst_pc", c_pc, 32'hFFFF_FFFC);
        chk("b_rst_pc", b_pc, 32'h1000_0040);
        chk("b_rst_req", {31'd0, b_req}, 32'd0);

        // jump and branch together: jump wins, top nibble from pc+4
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0800_0100;
        step();
        imem_ack = 1'b0;
        settle();
        chk("b_valid", {31'd0, b_valid}, 32'd1);
        is_jump      = 1'b1;
        is_branch    = 1'b1;
        branch_taken = 1'b1;
        imm16        = 16'h0001;
        addr26       = 26'h0000100;
        instr_ready  = 1'b1;
        step();
        instr_ready = 1'b0;
        clear_flags();
        settle();
        chk("b_jump_pc", b_pc, 32'h1000_0400);
        chk("b_jump_addr", b_addr, 32'h1000_0400);

        // sequential from the last word wraps to zero
        reset = 1'b1;
        step();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        step();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        settle();
        chk("c_wrap_pc", c_pc, 32'h0000_0000);
        chk("c_wrap_retired", c_ret, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address; bits [1:0] SHALL be treated as 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: byte address of the requested word.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: memory has imem_rdata valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port instruction, output, 32 bits: held instruction, driven to the control decoder.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: instruction is valid.
REQ-010 The block SHALL have port instr_ready, input, 1 bit: execute consumes the held instruction this cycle.
REQ-011 The block SHALL have ports is_jump, is_branch and branch_taken, inputs, 1 bit each, plus imm16 (input, 16 bits) and addr26 (input, 26 bits): decoder and datapath results for the held instruction.
REQ-012 The block SHALL have port pc, output, 32 bits: address of the held or in-flight instruction.
REQ-013 The block SHALL have port retired, output, 32 bits: count of consumed instructions.

Function
REQ-014 The FSM SHALL have two states: FETCH and HOLD.
REQ-015 In FETCH, imem_req SHALL be 1, imem_addr SHALL equal pc, instr_valid SHALL be 0, and instr_ready and decoder inputs SHALL be ignored.
REQ-016 In FETCH, imem_req and imem_addr SHALL stay stable until imem_ack=1 is sampled.
REQ-017 When FETCH samples imem_ack=1, the block SHALL latch instruction<=imem_rdata and go to HOLD, giving a minimum of 1 cycle from request to instr_valid.
REQ-018 imem_ack SHALL be ignored in HOLD.
REQ-019 In HOLD, imem_req SHALL be 0, instr_valid SHALL be 1, and instruction and pc SHALL stay stable while instr_ready=0.
REQ-020 In HOLD with instr_ready=1, the block SHALL do all of the following on that edge: pc<=next_pc, retired<=retired+1 (wrapping modulo 2^32), go to FETCH.
REQ-021 next_pc SHALL be computed combinationally from pc and the decoder inputs sampled in that same cycle, with pc4 = pc+4.
REQ-022 next_pc SHALL be {pc4[31:28], addr26, 2'b00} when is_jump=1.
REQ-023 next_pc SHALL be pc4 + (sign_extend(imm16) << 2) when is_jump=0, is_branch=1 and branch_taken=1.
REQ-024 next_pc SHALL be pc4 in all other cases.
REQ-025 If is_jump and is_branch are both 1, the jump SHALL take priority.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0x0000_0000; pc[1:0] SHALL always be 0.
REQ-027 Sustained throughput SHALL be at most one instruction per two cycles, with no speculative prefetch.

Reset
REQ-028 While reset=1, the block SHALL force: state=FETCH, pc=RESET_PC & ~3, instruction=0, instr_valid=0, retired=0.
REQ-029 While reset=1, imem_req SHALL be 0 and imem_addr SHALL equal RESET_PC & ~3.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.
REQ-031 Reset asserted in any state SHALL abandon that state: an in-progress fetch is dropped and any later imem_ack is ignored until FETCH is re-entered.
REQ-032 The first cycle after reset deasserts SHALL be FETCH with imem_req=1 at RESET_PC.

Verification
REQ-033 Reset with RESET_PC=0, release, then imem_ack=1 and imem_rdata=0x2010FEFE in the first cycle -> imem_req=1 and imem_addr=0 in that cycle; next cycle instruction=0x2010FEFE, instr_valid=1, pc=0.
REQ-034 Hold pc=0, then instr_ready=1 with all flags 0 -> pc=0x4, retired=1, imem_addr=0x4, imem_req=1.
REQ-035 Delay imem_ack for 3 cycles while driving instr_ready=1 -> imem_req and imem_addr stable for 4 cycles; instr_valid=0 throughout; retired unchanged.
REQ-036 Drive pc=0x10, is_branch=1, branch_taken=1, imm16=0xFFFD, then consume -> pc=0x08; with branch_taken=0 -> pc=0x14.
REQ-037 Drive pc=0x1000_0040, is_jump=1, is_branch=1, addr26=0x100, then consume -> pc=0x1000_0400; also pc=0xFFFF_FFFC sequential -> pc=0x0000_0000.
REQ-038 Assert reset during HOLD with retired=5 -> next cycle instr_valid=0, retired=0, pc=RESET_PC; a stale imem_ack during reset has no effect.
